// File: rtl/add_seq_arb_pkg.sv
// rtl/add_seq_arb_pkg.sv - shared widths and FSM state type for add_seq_arb
package add_seq_arb_pkg;
  localparam int DATA_W  = 16;
  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/cla8.sv
// rtl/cla8.sv - 8-bit carry-lookahead adder slice
module cla8
  import add_seq_arb_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_s,
  output logic               o_cout
);
  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W:0]   w_c;
  logic               w_acc;
  logic               w_prod;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is expanded as a flat sum of generate terms so no carry depends on another.
  always_comb begin
    w_c    = '0;
    w_acc  = 1'b0;
    w_prod = 1'b0;
    w_c[0] = i_cin;
    for (int i = 0; i < SLICE_W; i++) begin
      w_acc  = w_g[i];
      w_prod = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_acc  = w_acc | (w_prod & w_g[j]);
        w_prod = w_prod & w_p[j];
      end
      w_c[i+1] = w_acc | (w_prod & i_cin);
    end
  end

  assign o_s    = w_p ^ w_c[SLICE_W-1:0];
  assign o_cout = w_c[SLICE_W];
endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant; i_ptr names the favoured requester
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);
  assign o_grant = (i_valid == 2'b11) ? (i_ptr ? 2'b10 : 2'b01) : i_valid;
endmodule

// File: rtl/add_seq_arb.sv
// rtl/add_seq_arb.sv - two-requester 16-bit adder sharing one 8-bit CLA slice over two cycles
// ADD_SEQ_ARB_BYPASS_EN: accept the next add in the same cycle a response is taken.
module add_seq_arb
  import add_seq_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_A,
  input  logic [DATA_W-1:0] req0_B,
  input  logic              req0_C_in,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_A,
  input  logic [DATA_W-1:0] req1_B,
  input  logic              req1_C_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_S,
  output logic              rsp_Cout,
  output logic              rsp_Ovfl,
  output logic              rsp_id
);
  state_e            r_state;
  logic              r_ptr;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_cin;
  logic              r_id;
  logic              r_carry;
  logic [DATA_W-1:0] r_s;
  logic              r_cout;
  logic              r_ovfl;

  logic [1:0]         w_grant;
  logic               w_accept_win;
  logic               w_accept;
  logic               w_hi;
  logic [SLICE_W-1:0] w_sa;
  logic [SLICE_W-1:0] w_sb;
  logic               w_scin;
  logic [SLICE_W-1:0] w_sum;
  logic               w_sco;

  rr_arb2 u_arb (
    .i_valid ({req1_valid, req0_valid}),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

`ifdef ADD_SEQ_ARB_BYPASS_EN
  assign w_accept_win = (r_state == ST_IDLE) || ((r_state == ST_DONE) && rsp_ready);
`else
  assign w_accept_win = (r_state == ST_IDLE);
`endif

  // Ready is gated by rst so an asynchronous reset drops it in the same cycle.
  assign w_accept   = w_accept_win && !rst && (|w_grant);
  assign req0_ready = w_accept_win && !rst && w_grant[0];
  assign req1_ready = w_accept_win && !rst && w_grant[1];

  assign w_hi   = (r_state == ST_HI);
  assign w_sa   = w_hi ? r_a[DATA_W-1:SLICE_W] : r_a[SLICE_W-1:0];
  assign w_sb   = w_hi ? r_b[DATA_W-1:SLICE_W] : r_b[SLICE_W-1:0];
  assign w_scin = w_hi ? r_carry : r_cin;

  cla8 u_slice (
    .i_a    (w_sa),
    .i_b    (w_sb),
    .i_cin  (w_scin),
    .o_s    (w_sum),
    .o_cout (w_sco)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_id    <= 1'b0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovfl  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_IDLE;
        ST_LO: begin
          r_s[SLICE_W-1:0] <= w_sum;
          r_carry          <= w_sco;
          r_state          <= ST_HI;
        end
        ST_HI: begin
          r_s[DATA_W-1:SLICE_W] <= w_sum;
          r_cout                <= w_sco;
          r_ovfl                <= (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
                                   (w_sum[SLICE_W-1] != r_a[DATA_W-1]);
          r_state               <= ST_DONE;
        end
        ST_DONE: if (rsp_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      // An accept overrides the case above, which matters only for the DONE bypass.
      if (w_accept) begin
        r_state <= ST_LO;
        r_ptr   <= w_grant[0];
        r_id    <= w_grant[1];
        r_a     <= w_grant[1] ? req1_A    : req0_A;
        r_b     <= w_grant[1] ? req1_B    : req0_B;
        r_cin   <= w_grant[1] ? req1_C_in : req0_C_in;
      end
    end
  end

  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_S     = r_s;
  assign rsp_Cout  = r_cout;
  assign rsp_Ovfl  = r_ovfl;
  assign rsp_id    = r_id;
endmodule

// File: tb/tb_add_seq_arb.sv
// tb/tb_add_seq_arb.sv - randomized self-checking bench for add_seq_arb against a transaction-level model
module tb_add_seq_arb;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req0_C_in;
  logic req1_valid, req1_ready, req1_C_in;
  logic [15:0] req0_A, req0_B, req1_A, req1_B, rsp_S;
  logic rsp_valid, rsp_ready, rsp_Cout, rsp_Ovfl, rsp_id;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        id;
  } rsp_t;

`ifdef ADD_SEQ_ARB_BYPASS_EN
  localparam bit BYP     = 1'b1;
  localparam int SPACING = 3;
`else
  localparam bit BYP     = 1'b0;
  localparam int SPACING = 4;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        pend[2];
  logic [15:0] pa[2];
  logic [15:0] pb[2];
  logic        pc[2];
  rsp_t        pexp[2];
  logic        inflight;
  int          acc_cyc;
  rsp_t        cur;
  logic        ptr;
  logic        drv_rst, drv_rready, auto_fill;
  logic        last_rv, last_done, last_hs;
  int          gq_id[$];
  int          gq_cyc[$];

  add_seq_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_A     (req0_A),
    .req0_B     (req0_B),
    .req0_C_in  (req0_C_in),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_A     (req1_A),
    .req1_B     (req1_B),
    .req1_C_in  (req1_C_in),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_S      (rsp_S),
    .rsp_Cout   (rsp_Cout),
    .rsp_Ovfl   (rsp_Ovfl),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic rsp_t ref_add(input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input logic id);
    rsp_t r;
    int   u;
    int   sg;
    u    = int'(a) + int'(b) + int'(c);
    sg   = int'($signed(a)) + int'($signed(b)) + int'(c);
    r.s  = u[15:0];
    r.co = (u > 65535);
    r.ov = (sg > 32767) || (sg < -32768);
    r.id = id;
    return r;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic push(input int i, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input rsp_t e);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
    pc[i]   = c;
    pexp[i] = e;
  endtask

  task automatic push_rand(input int i);
    logic [15:0] a, b;
    logic        c;
    a = pick();
    b = pick();
    c = 1'($urandom_range(0, 1));
    push(i, a, b, c, ref_add(a, b, c, 1'(i)));
  endtask

  // One clock: drive at negedge, compare at negedge+1, then advance the model.
  task automatic step();
    logic exp_rv, done, permit;
    int   g;
    @(negedge clk);
    if (auto_fill) begin
      for (int i = 0; i < 2; i++) if (!pend[i]) push_rand(i);
    end
    rst        = drv_rst;
    rsp_ready  = drv_rready;
    req0_valid = pend[0];
    req0_A     = pa[0];
    req0_B     = pb[0];
    req0_C_in  = pc[0];
    req1_valid = pend[1];
    req1_A     = pa[1];
    req1_B     = pb[1];
    req1_C_in  = pc[1];
    #1;
    exp_rv = !drv_rst && inflight && (cyc >= acc_cyc + 3);
    done   = exp_rv && drv_rready;
    permit = !drv_rst && (!inflight || (BYP && done));
    g = -1;
    if (permit) begin
      if (pend[0] && pend[1]) g = int'(ptr);
      else if (pend[0])       g = 0;
      else if (pend[1])       g = 1;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    if (exp_rv) begin
      chk("rsp_S", 32'(rsp_S), 32'(cur.s));
      chk("rsp_Cout", 32'(rsp_Cout), 32'(cur.co));
      chk("rsp_Ovfl", 32'(rsp_Ovfl), 32'(cur.ov));
      chk("rsp_id", 32'(rsp_id), 32'(cur.id));
    end
    if (drv_rst) begin
      chk("rst_S", 32'(rsp_S), 32'd0);
      chk("rst_Cout", 32'(rsp_Cout), 32'd0);
      chk("rst_Ovfl", 32'(rsp_Ovfl), 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
    end
    if (req0_ready) begin gq_id.push_back(0); gq_cyc.push_back(cyc); end
    if (req1_ready) begin gq_id.push_back(1); gq_cyc.push_back(cyc); end
    last_hs = rsp_valid && rsp_ready;
    if (done) inflight = 1'b0;
    if (drv_rst) begin
      inflight = 1'b0;
      ptr      = 1'b0;
    end
    if (g >= 0) begin
      inflight = 1'b1;
      acc_cyc  = cyc;
      cur      = pexp[g];
      pend[g]  = 1'b0;
      ptr      = (g == 0);
    end
    last_rv   = exp_rv;
    last_done = done;
    cyc++;
  endtask

  task automatic directed(input int i, input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] s, input logic co, input logic ov);
    rsp_t e;
    int   n;
    e.s  = s;
    e.co = co;
    e.ov = ov;
    e.id = 1'(i);
    push(i, a, b, c, e);
    n = 0;
    do begin
      step();
      n++;
    end while (!last_done && n < 20);
    chk("directed_done", 32'(last_hs), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    drv_rready = 1'b1;
    while ((inflight || pend[0] || pend[1]) && n < 40) begin
      step();
      n++;
    end
    chk("drain", 32'(inflight || pend[0] || pend[1]), 32'd0);
  endtask

  initial begin
    int   n;
    rsp_t e;
    rst = 1'b1;
    drv_rst = 1'b1; drv_rready = 1'b1; auto_fill = 1'b0;
    inflight = 1'b0; ptr = 1'b0; acc_cyc = 0; cur = '0;
    last_rv = 1'b0; last_done = 1'b0; last_hs = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pc[i] = 1'b0; pexp[i] = '0;
    end
    req0_valid = 1'b0; req0_A = '0; req0_B = '0; req0_C_in = 1'b0;
    req1_valid = 1'b0; req1_A = '0; req1_B = '0; req1_C_in = 1'b0;
    rsp_ready = 1'b1;

    // reset held with both requesters asserting: no ready, outputs cleared
    push_rand(0);
    push_rand(1);
    repeat (3) step();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drv_rst = 1'b0;

    directed(0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    directed(1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed(0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    directed(1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    directed(0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

    // both requesters continuously valid from reset
    drv_rst = 1'b1;
    step();
    drv_rst = 1'b0;
    gq_id.delete();
    gq_cyc.delete();
    auto_fill = 1'b1;
    repeat (18) step();
    auto_fill = 1'b0;
    chk("rr_count", 32'(gq_id.size() >= 4), 32'd1);
    if (gq_id.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("rr_grant", 32'(gq_id[k]), 32'(k % 2));
        if (k > 0) chk("rr_spacing", 32'(gq_cyc[k] - gq_cyc[k-1]), 32'(SPACING));
      end
    end
    drain();

    // consumer stalls five cycles in DONE, completes on the sixth
    e.s = 16'h5556; e.co = 1'b0; e.ov = 1'b0; e.id = 1'b0;
    push(0, 16'h1234, 16'h4321, 1'b1, e);
    e.s = 16'h0000; e.co = 1'b1; e.ov = 1'b1; e.id = 1'b1;
    push(1, 16'h8000, 16'h8000, 1'b0, e);
    drv_rready = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_rv && n < 10);
    chk("hold_reach", 32'(rsp_valid), 32'd1);
    repeat (4) step();
    chk("hold_no_hs", 32'(last_hs), 32'd0);
    drv_rready = 1'b1;
    step();
    chk("hold_complete", 32'(last_hs), 32'd1);
    drain();

    // reset pulse while the slice works on the high byte
    push_rand(0);
    n = 0;
    while (!(inflight && cyc == acc_cyc + 2) && n < 10) begin
      step();
      n++;
    end
    chk("hi_reach", 32'(inflight && cyc == acc_cyc + 2), 32'd1);
    push_rand(1);
    drv_rst = 1'b1;
    step();
    drv_rst = 1'b0;
    push_rand(0);
    gq_id.delete();
    gq_cyc.delete();
    repeat (6) step();
    chk("post_rst_grant", 32'(gq_id.size() > 0 ? gq_id[0] : 9), 32'd0);
    drain();

    // randomized traffic with random consumer backpressure
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(0, 2) == 0) push_rand(i);
      drv_rready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
